// File: rtl/sni_rx_fcs.sv
// SNI 10 Mb/s receive front end: preamble/SFD strip, LSB-first byte assembly,
// CRC-32 and length check, optional FCS strip, FIFO write with eod/err sideband.
module sni_rx_fcs #(
  parameter int STRIP_FCS = 1,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             RXC,
  input  logic             arst_n,
  input  logic             CRS,
  input  logic             RXD,
  input  logic             fifo_afull,
  output logic [7:0]       fifo_din,
  output logic             fifo_wren,
  output logic             fifo_eod,
  output logic             fifo_err,
  output logic [CNT_W-1:0] stat_good,
  output logic [CNT_W-1:0] stat_bad,
  output logic [CNT_W-1:0] stat_drop
);
  localparam int D    = (STRIP_FCS != 0) ? 5 : 1;
  localparam int BC_W = $clog2(MAX_LEN + 2);
  localparam logic [BC_W-1:0] MIN_B = BC_W'(MIN_LEN);
  localparam logic [BC_W-1:0] MAX_B = BC_W'(MAX_LEN);
  localparam logic [BC_W-1:0] SAT_B = BC_W'(MAX_LEN + 1);
  localparam logic [BC_W-1:0] D_B   = BC_W'(D);
  localparam logic [31:0] POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] MAGIC = 32'hC704_DD7B;
  localparam logic [7:0]  SFD   = 8'hAB;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_BODY = 3'd2;
  localparam logic [2:0] S_END  = 3'd3;
  localparam logic [2:0] S_TERM = 3'd4;
  localparam logic [2:0] S_SKIP = 3'd5;

  logic [2:0]            state;
  logic [7:0]            raw;
  logic [2:0]            bit_cnt;
  logic [6:0]            byte_q;
  logic [BC_W-1:0]       byte_cnt;
  logic [31:0]           crc;
  logic [D-1:0][7:0]     dl;
  logic [7:0]            nb;
  logic                  frame_bad;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic d);
    return {c[30:0], 1'b0} ^ ({32{c[31] ^ d}} & POLY);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Bits arrive LSB first, so the completing bit is the byte's MSB.
  assign nb        = {RXD, byte_q};
  assign frame_bad = (bit_cnt != 3'd0) || (crc != MAGIC) ||
                     (byte_cnt < MIN_B) || (byte_cnt > MAX_B);

  always_ff @(posedge RXC or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      raw       <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_q    <= 7'h00;
      byte_cnt  <= '0;
      crc       <= 32'hFFFF_FFFF;
      dl        <= '0;
      fifo_din  <= 8'h00;
      fifo_wren <= 1'b0;
      fifo_eod  <= 1'b0;
      fifo_err  <= 1'b0;
      stat_good <= '0;
      stat_bad  <= '0;
      stat_drop <= '0;
    end else begin
      raw       <= {raw[6:0], RXD};
      fifo_wren <= 1'b0;
      fifo_eod  <= 1'b0;
      fifo_err  <= 1'b0;
      case (state)
        S_IDLE: if (CRS) state <= S_PRE;
        S_PRE: begin
          if (!CRS) state <= S_IDLE;
          else if (raw == SFD) begin
            if (fifo_afull) begin
              state     <= S_SKIP;
              stat_drop <= sat_inc(stat_drop);
            end else begin
              // SFD is seen one cycle late, so this cycle's bit is data bit 0.
              state    <= S_BODY;
              crc      <= crc_step(32'hFFFF_FFFF, RXD);
              byte_q   <= {RXD, byte_q[6:1]};
              bit_cnt  <= 3'd1;
              byte_cnt <= '0;
            end
          end
        end
        S_BODY: begin
          if (!CRS) begin
            state     <= S_END;
            fifo_wren <= 1'b1;
            fifo_eod  <= 1'b1;
            if (byte_cnt < D_B) begin
              fifo_din <= 8'h00;
              fifo_err <= 1'b1;
            end else begin
              fifo_din <= dl[D-1];
              fifo_err <= frame_bad;
            end
            if (frame_bad) stat_bad  <= sat_inc(stat_bad);
            else           stat_good <= sat_inc(stat_good);
          end else begin
            crc     <= crc_step(crc, RXD);
            byte_q  <= {RXD, byte_q[6:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt != SAT_B) byte_cnt <= byte_cnt + 1'b1;
              if ((byte_cnt >= MAX_B) || ((byte_cnt >= D_B) && fifo_afull)) begin
                // Oversize or no room: close the frame in the reserved slot.
                state     <= S_TERM;
                fifo_wren <= 1'b1;
                fifo_eod  <= 1'b1;
                fifo_err  <= 1'b1;
                fifo_din  <= 8'h00;
                stat_bad  <= sat_inc(stat_bad);
              end else begin
                for (int i = D - 1; i > 0; i--) dl[i] <= dl[i-1];
                dl[0] <= nb;
                if (byte_cnt >= D_B) begin
                  fifo_wren <= 1'b1;
                  fifo_din  <= dl[D-1];
                end
              end
            end
          end
        end
        S_END:   state <= S_IDLE;
        S_TERM:  state <= S_SKIP;
        S_SKIP:  if (!CRS) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sni_rx_fcs.sv
// Scoreboard bench: one FCS-stripping instance and one FCS-keeping, 2-bit-counter
// instance; expected FIFO writes are queued from a frame model as frames are sent.
module tb_sni_rx_fcs;
  localparam int MINL = 64;
  localparam int MAXL = 1518;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [1:0] crs, afull;
  logic       rxd;
  logic [7:0] din1, din0;
  logic       wren1, wren0, eod1, eod0, err1, err0;
  logic [15:0] good1, bad1, drop1;
  logic [1:0]  good0, bad0, drop0;

  always #5 clk = ~clk;

  sni_rx_fcs #(.STRIP_FCS(1), .MIN_LEN(MINL), .MAX_LEN(MAXL), .CNT_W(16)) u_strip (
    .RXC(clk), .arst_n(arst_n), .CRS(crs[1]), .RXD(rxd), .fifo_afull(afull[1]),
    .fifo_din(din1), .fifo_wren(wren1), .fifo_eod(eod1), .fifo_err(err1),
    .stat_good(good1), .stat_bad(bad1), .stat_drop(drop1));

  sni_rx_fcs #(.STRIP_FCS(0), .MIN_LEN(MINL), .MAX_LEN(MAXL), .CNT_W(2)) u_keep (
    .RXC(clk), .arst_n(arst_n), .CRS(crs[0]), .RXD(rxd), .fifo_afull(afull[0]),
    .fifo_din(din0), .fifo_wren(wren0), .fifo_eod(eod0), .fifo_err(err0),
    .stat_good(good0), .stat_bad(bad0), .stat_drop(drop0));

  int n_chk = 0;
  int n_err = 0;
  int nwr1 = 0;
  int nwr0 = 0;
  int eg[2], eb[2], ed[2];
  logic [9:0] q1[$], q0[$];
  logic [7:0] tx[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each write compares {valid, din, eod, err}; an unexpected write meets valid=0.
  always @(negedge clk) begin : mon_strip
    logic [10:0] e;
    if (wren1) begin
      e = (q1.size() > 0) ? {1'b1, q1.pop_front()} : 11'h0;
      chk("wr_strip", {21'h0, 1'b1, din1, eod1, err1}, {21'h0, e});
      nwr1++;
    end
  end

  always @(negedge clk) begin : mon_keep
    logic [10:0] e;
    if (wren0) begin
      e = (q0.size() > 0) ? {1'b1, q0.pop_front()} : 11'h0;
      chk("wr_keep", {21'h0, 1'b1, din0, eod0, err0}, {21'h0, e});
      nwr0++;
    end
  end

  task automatic build(input int n_data);
    logic [31:0] c;
    tx.delete();
    repeat (n_data) tx.push_back(8'($urandom));
    c = 32'hFFFF_FFFF;
    foreach (tx[i]) begin
      c ^= {24'h0, tx[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) tx.push_back(c[8*i +: 8]);
  endtask

  task automatic push_exp(input int sel, input logic [7:0] d, input logic eod, input logic err);
    if (sel == 1) q1.push_back({d, eod, err});
    else          q0.push_back({d, eod, err});
  endtask

  function automatic int sat(input int sel, input int v);
    int mx;
    mx = (sel == 1) ? 65535 : 3;
    return (v < mx) ? v + 1 : v;
  endfunction

  // Frame-level model of the expected FIFO traffic and counter updates.
  task automatic model(input int sel, input int drib, input bit corrupt, input int af);
    int n, d, w;
    bit bad;
    n = tx.size();
    d = (sel == 1) ? 5 : 1;
    w = 0;
    if (af == 0) begin
      ed[sel] = sat(sel, ed[sel]);
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (k >= MAXL || (k >= d && w >= af)) begin
        push_exp(sel, 8'h00, 1'b1, 1'b1);
        eb[sel] = sat(sel, eb[sel]);
        return;
      end
      if (k >= d) begin
        push_exp(sel, tx[k-d], 1'b0, 1'b0);
        w++;
      end
    end
    bad = (drib != 0) || corrupt || (n < MINL) || (n > MAXL);
    if (n < d) push_exp(sel, 8'h00, 1'b1, 1'b1);
    else       push_exp(sel, tx[n-d], 1'b1, bad);
    if (bad) eb[sel] = sat(sel, eb[sel]);
    else     eg[sel] = sat(sel, eg[sel]);
  endtask

  task automatic drive(input int sel, input logic c, input logic b, input int base, input int af);
    int nw;
    @(posedge clk);
    #1;
    nw = ((sel == 1) ? nwr1 : nwr0) - base;
    crs[sel]   = c;
    rxd        = b;
    afull[sel] = c && (nw >= af);
  endtask

  task automatic send(input int sel, input int drib, input int af);
    int base;
    logic [7:0] p, t;
    base = (sel == 1) ? nwr1 : nwr0;
    for (int i = 0; i < 8; i++) begin
      p = (i == 7) ? 8'hD5 : 8'h55;
      for (int b = 0; b < 8; b++) drive(sel, 1'b1, p[b], base, af);
    end
    foreach (tx[i]) begin
      t = tx[i];
      for (int b = 0; b < 8; b++) drive(sel, 1'b1, t[b], base, af);
    end
    repeat (drib) drive(sel, 1'b1, 1'($urandom), base, af);
    repeat (24) drive(sel, 1'b0, 1'b0, base, af);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_q1"}, q1.size(), 0);
    chk({tag, "_q0"}, q0.size(), 0);
    chk({tag, "_good1"}, {16'h0, good1}, eg[1]);
    chk({tag, "_bad1"},  {16'h0, bad1},  eb[1]);
    chk({tag, "_drop1"}, {16'h0, drop1}, ed[1]);
    chk({tag, "_good0"}, {30'h0, good0}, eg[0]);
    chk({tag, "_bad0"},  {30'h0, bad0},  eb[0]);
    chk({tag, "_drop0"}, {30'h0, drop0}, ed[0]);
  endtask

  task automatic frame(input string tag, input int sel, input int drib, input bit corrupt,
                       input int af);
    model(sel, drib, corrupt, af);
    send(sel, drib, af);
    check_idle(tag);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin eg[i] = 0; eb[i] = 0; ed[i] = 0; end
    arst_n = 1'b0; crs = 2'b00; afull = 2'b00; rxd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out1",  {21'h0, din1, wren1, eod1, err1}, 32'h0);
    chk("rst_out0",  {21'h0, din0, wren0, eod0, err0}, 32'h0);
    chk("rst_stat1", {good1, bad1}, 32'h0);
    chk("rst_stat0", {26'h0, good0, bad0, drop0}, 32'h0);
    chk("rst_drop1", {16'h0, drop1}, 32'h0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    repeat (4) @(posedge clk);

    build(60);            frame("good64", 1, 0, 1'b0, NEVER);
    build(60); tx[62] ^= 8'h10;
                          frame("badfcs", 1, 0, 1'b1, NEVER);
    build(60);            frame("dribble", 1, 3, 1'b0, NEVER);
    build(36);            frame("runt", 1, 0, 1'b0, NEVER);
    build(1516);          frame("long", 1, 0, 1'b0, NEVER);
    build(60);            frame("afull20", 1, 0, 1'b0, 20);
    build(60);            frame("afullsfd", 1, 0, 1'b0, 0);

    // Carrier that dies inside the preamble leaves no trace.
    for (int i = 0; i < 20; i++) drive(1, 1'b1, 1'(~i[0]), nwr1, NEVER);
    repeat (16) drive(1, 1'b0, 1'b0, nwr1, NEVER);
    check_idle("predrop");

    for (int r = 0; r < 4; r++) begin
      build(60);
      frame("keep64", 0, 0, 1'b0, NEVER);
    end
    chk("keep_sat", {30'h0, good0}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
